// File: rtl/proc_pkg.sv
// ============================================================================
// proc_pkg
// Shared pipeline types: forward-source select and shadow stage record.
// Revision: 1.0
// ============================================================================
`default_nettype none
package proc_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_M    = 2'd1,
      FWD_W    = 2'd2
   } fwd_sel_t;

   typedef struct packed {
      logic       valid;
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses_rs1;
      logic       uses_rs2;
      logic       writes_rd;
   } stage_t;

   localparam stage_t C_STAGE_EMPTY = '0;

endpackage
`default_nettype wire

// File: rtl/inst_reg_use.sv
// ============================================================================
// inst_reg_use
// Classifies an opcode by which register fields it reads and writes.
// Revision: 1.0
// ============================================================================
`default_nettype none
`include "proc_define.sv"

module inst_reg_use (
   input  logic [6:0] opcode,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       writes_rd
);

   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         `RTYPE: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            writes_rd = 1'b1;
         end
         `ITYPE_ALU, `LOAD: begin
            uses_rs1  = 1'b1;
            writes_rd = 1'b1;
         end
         `STORE, `BRANCH: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
         end
         `JAL: writes_rd = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/proc_define.sv
// ============================================================================
// proc_define
// Major opcode macros for the RV32I instruction classes seen by the pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef PROC_DEFINE_SV
`define PROC_DEFINE_SV

`define RTYPE     7'b0110011
`define ITYPE_ALU 7'b0010011
`define LOAD      7'b0000011
`define STORE     7'b0100011
`define BRANCH    7'b1100011
`define JAL       7'b1101111

`endif
`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit
// Shadow X/M/W tracker producing stall, bubble, flush, freeze and forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none
`include "proc_define.sv"

module hazard_unit
   import proc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [31:0]      d_inst_i,
   input  logic             d_valid_i,
   input  logic             x_branch_taken_i,
   input  logic             m_mem_ready_i,
   output logic             stall_d_o,
   output logic             bubble_x_o,
   output logic             flush_o,
   output logic             freeze_o,
   output fwd_sel_t         fwd1_sel_o,
   output fwd_sel_t         fwd2_sel_o,
   output logic             x_valid_o,
   output logic             m_valid_o,
   output logic             w_valid_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   stage_t           r_x, r_m, r_w;
   stage_t           w_d;
   logic             w_d_uses_rs1, w_d_uses_rs2, w_d_writes_rd;
   logic             w_freeze, w_flush, w_load_use;
   logic [CNT_W-1:0] r_cnt;
   logic             w_unused_bits;

   inst_reg_use u_d_use (
      .opcode    (d_inst_i[6:0]),
      .uses_rs1  (w_d_uses_rs1),
      .uses_rs2  (w_d_uses_rs2),
      .writes_rd (w_d_writes_rd)
   );

   always_comb begin
      w_d           = C_STAGE_EMPTY;
      w_d.valid     = d_valid_i;
      w_d.opcode    = d_inst_i[6:0];
      w_d.rd        = d_inst_i[11:7];
      w_d.rs1       = d_inst_i[19:15];
      w_d.rs2       = d_inst_i[24:20];
      w_d.uses_rs1  = w_d_uses_rs1;
      w_d.uses_rs2  = w_d_uses_rs2;
      w_d.writes_rd = w_d_writes_rd;
   end

   assign w_freeze = r_m.valid && ((r_m.opcode == `LOAD) || (r_m.opcode == `STORE))
                     && !m_mem_ready_i;
   assign w_flush  = x_branch_taken_i && r_x.valid && !w_freeze;
   assign w_load_use = !w_freeze && !w_flush && r_x.valid && (r_x.opcode == `LOAD)
                       && (r_x.rd != 5'd0) && w_d.valid
                       && ((w_d.uses_rs1 && (w_d.rs1 == r_x.rd))
                        || (w_d.uses_rs2 && (w_d.rs2 == r_x.rd)));

   // A matching M-stage load yields no forward rather than falling back to W.
   function automatic fwd_sel_t pick_fwd(input logic   src_used,
                                         input logic [4:0] src,
                                         input stage_t m,
                                         input stage_t w);
      fwd_sel_t sel;
      sel = FWD_NONE;
      if (src_used) begin
         if (m.valid && m.writes_rd && (m.rd != 5'd0) && (m.rd == src))
            sel = (m.opcode == `LOAD) ? FWD_NONE : FWD_M;
         else if (w.valid && w.writes_rd && (w.rd != 5'd0) && (w.rd == src))
            sel = FWD_W;
      end
      return sel;
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_x   <= C_STAGE_EMPTY;
         r_m   <= C_STAGE_EMPTY;
         r_w   <= C_STAGE_EMPTY;
         r_cnt <= '0;
      end else begin
         if (!w_freeze) begin
            r_w <= r_m;
            r_m <= r_x;
            r_x <= w_d;
            if (w_flush || w_load_use)
               r_x.valid <= 1'b0;
         end
         if ((w_load_use || w_freeze) && (r_cnt != C_CNT_MAX))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign stall_d_o      = w_load_use;
   assign bubble_x_o     = w_load_use;
   assign flush_o        = w_flush;
   assign freeze_o       = w_freeze;
   assign fwd1_sel_o     = pick_fwd(r_x.valid && r_x.uses_rs1, r_x.rs1, r_m, r_w);
   assign fwd2_sel_o     = pick_fwd(r_x.valid && r_x.uses_rs2, r_x.rs2, r_m, r_w);
   assign x_valid_o      = r_x.valid;
   assign m_valid_o      = r_m.valid;
   assign w_valid_o      = r_w.valid;
   assign stall_cycles_o = r_cnt;

   assign w_unused_bits = ^{r_m.rs1, r_m.rs2, r_m.uses_rs1, r_m.uses_rs2,
                            r_w.opcode, r_w.rs1, r_w.rs2, r_w.uses_rs1, r_w.uses_rs2,
                            d_inst_i[31:25], d_inst_i[14:12]};

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// tb_hazard_unit
// Directed-vector bench for hazard_unit (default and 4-bit counter instances).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit;
   import proc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        dv, br, rdy;

   logic        stall, bubble, flush, freeze, xv, mv, wv;
   fwd_sel_t    fwd1, fwd2;
   logic [15:0] cnt;

   logic        s4_stall, s4_bubble, s4_flush, s4_freeze, s4_xv, s4_mv, s4_wv;
   fwd_sel_t    s4_fwd1, s4_fwd2;
   logic [3:0]  cnt4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_unit dut (
      .clk_i(clk), .rst_n_i(rst_n), .d_inst_i(inst), .d_valid_i(dv),
      .x_branch_taken_i(br), .m_mem_ready_i(rdy),
      .stall_d_o(stall), .bubble_x_o(bubble), .flush_o(flush), .freeze_o(freeze),
      .fwd1_sel_o(fwd1), .fwd2_sel_o(fwd2),
      .x_valid_o(xv), .m_valid_o(mv), .w_valid_o(wv), .stall_cycles_o(cnt)
   );

   hazard_unit #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n), .d_inst_i(inst), .d_valid_i(dv),
      .x_branch_taken_i(br), .m_mem_ready_i(rdy),
      .stall_d_o(s4_stall), .bubble_x_o(s4_bubble), .flush_o(s4_flush),
      .freeze_o(s4_freeze), .fwd1_sel_o(s4_fwd1), .fwd2_sel_o(s4_fwd2),
      .x_valid_o(s4_xv), .m_valid_o(s4_mv), .w_valid_o(s4_wv), .stall_cycles_o(cnt4)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] lw_i(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'b0, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   // Inputs change just after the rising edge; checks happen at the falling edge.
   task automatic step(input logic [31:0] i, input logic v, input logic b, input logic r);
      @(posedge clk);
      #1;
      inst = i; dv = v; br = b; rdy = r;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; inst = '0; dv = 1'b0; br = 1'b0; rdy = 1'b1;
      idle(2);
      check("rst_stall",  32'(stall),  0);
      check("rst_bubble", 32'(bubble), 0);
      check("rst_flush",  32'(flush),  0);
      check("rst_freeze", 32'(freeze), 0);
      check("rst_fwd1",   32'(fwd1),   32'(FWD_NONE));
      check("rst_fwd2",   32'(fwd2),   32'(FWD_NONE));
      check("rst_xv",     32'(xv),     0);
      check("rst_mv",     32'(mv),     0);
      check("rst_wv",     32'(wv),     0);
      check("rst_cnt",    32'(cnt),    0);
      rst_n = 1'b1;

      // Back-to-back ALU dependency forwards from M
      step(add_i(5, 1, 2), 1'b1, 1'b0, 1'b1);
      check("alu_stall0", 32'(stall), 0);
      step(add_i(6, 5, 3), 1'b1, 1'b0, 1'b1);
      check("alu_stall1", 32'(stall), 0);
      check("alu_fwd1_pre", 32'(fwd1), 32'(FWD_NONE));
      step(32'h0, 1'b0, 1'b0, 1'b1);
      check("alu_fwd1_m", 32'(fwd1), 32'(FWD_M));
      check("alu_fwd2_none", 32'(fwd2), 32'(FWD_NONE));
      check("alu_xv", 32'(xv), 1);
      check("alu_mv", 32'(mv), 1);
      step(32'h0, 1'b0, 1'b0, 1'b1);
      check("alu_xv_drain", 32'(xv), 0);
      check("alu_fwd1_drain", 32'(fwd1), 32'(FWD_NONE));
      idle(3);

      // Same rd in M and W: M wins
      step(add_i(5, 1, 2), 1'b1, 1'b0, 1'b1);
      step(add_i(5, 1, 2), 1'b1, 1'b0, 1'b1);
      step(add_i(6, 5, 5), 1'b1, 1'b0, 1'b1);
      step(32'h0, 1'b0, 1'b0, 1'b1);
      check("prio_fwd1", 32'(fwd1), 32'(FWD_M));
      check("prio_fwd2", 32'(fwd2), 32'(FWD_M));
      idle(3);

      // rs1 from W, rs2 from M
      step(add_i(9, 1, 2), 1'b1, 1'b0, 1'b1);
      step(add_i(10, 1, 2), 1'b1, 1'b0, 1'b1);
      step(add_i(11, 9, 10), 1'b1, 1'b0, 1'b1);
      step(32'h0, 1'b0, 1'b0, 1'b1);
      check("mix_fwd1_w", 32'(fwd1), 32'(FWD_W));
      check("mix_fwd2_m", 32'(fwd2), 32'(FWD_M));
      idle(3);

      // Load-use: one stall cycle, then both operands from W
      step(lw_i(7, 1), 1'b1, 1'b0, 1'b1);
      check("lu_stall_pre", 32'(stall), 0);
      step(add_i(8, 7, 7), 1'b1, 1'b0, 1'b1);
      check("lu_stall", 32'(stall), 1);
      check("lu_bubble", 32'(bubble), 1);
      check("lu_cnt0", 32'(cnt), 0);
      step(add_i(8, 7, 7), 1'b1, 1'b0, 1'b1);
      check("lu_stall_once", 32'(stall), 0);
      check("lu_bubble_x", 32'(xv), 0);
      check("lu_load_m", 32'(mv), 1);
      check("lu_cnt1", 32'(cnt), 1);
      step(32'h0, 1'b0, 1'b0, 1'b1);
      check("lu_fwd1_w", 32'(fwd1), 32'(FWD_W));
      check("lu_fwd2_w", 32'(fwd2), 32'(FWD_W));
      check("lu_xv", 32'(xv), 1);
      idle(3);

      // Freeze for three cycles over a pending load-use hazard
      step(lw_i(7, 1), 1'b1, 1'b0, 1'b1);
      step(lw_i(9, 1), 1'b1, 1'b0, 1'b1);
      check("fz_stall_pre", 32'(stall), 0);
      step(add_i(8, 9, 9), 1'b1, 1'b0, 1'b0);
      check("fz_freeze1", 32'(freeze), 1);
      check("fz_stall_masked", 32'(stall), 0);
      check("fz_bubble_masked", 32'(bubble), 0);
      check("fz_flush_masked", 32'(flush), 0);
      step(add_i(8, 9, 9), 1'b1, 1'b0, 1'b0);
      check("fz_freeze2", 32'(freeze), 1);
      check("fz_cnt2", 32'(cnt), 2);
      step(add_i(8, 9, 9), 1'b1, 1'b0, 1'b0);
      check("fz_freeze3", 32'(freeze), 1);
      check("fz_cnt3", 32'(cnt), 3);
      check("fz_wv_hold", 32'(wv), 0);
      check("fz_xv_hold", 32'(xv), 1);
      check("fz_mv_hold", 32'(mv), 1);
      step(add_i(8, 9, 9), 1'b1, 1'b0, 1'b1);
      check("fz_release", 32'(freeze), 0);
      check("fz_lu_after", 32'(stall), 1);
      check("fz_cnt4", 32'(cnt), 4);
      step(add_i(8, 9, 9), 1'b1, 1'b0, 1'b1);
      check("fz_lu_once", 32'(stall), 0);
      check("fz_cnt5", 32'(cnt), 5);
      check("fz_bubble_x", 32'(xv), 0);
      idle(3);

      // Taken branch overrides load-use
      step(lw_i(7, 1), 1'b1, 1'b0, 1'b1);
      step(add_i(8, 7, 7), 1'b1, 1'b1, 1'b1);
      check("br_flush", 32'(flush), 1);
      check("br_stall", 32'(stall), 0);
      check("br_bubble", 32'(bubble), 0);
      step(32'h0, 1'b0, 1'b0, 1'b1);
      check("br_xv", 32'(xv), 0);
      check("br_mv", 32'(mv), 1);
      check("br_cnt", 32'(cnt), 5);
      idle(3);

      // x0 is never a forward source or hazard
      step(add_i(0, 1, 2), 1'b1, 1'b0, 1'b1);
      step(add_i(3, 0, 0), 1'b1, 1'b0, 1'b1);
      check("x0_stall", 32'(stall), 0);
      step(32'h0, 1'b0, 1'b0, 1'b1);
      check("x0_fwd1", 32'(fwd1), 32'(FWD_NONE));
      check("x0_fwd2", 32'(fwd2), 32'(FWD_NONE));
      idle(3);
      step(lw_i(0, 1), 1'b1, 1'b0, 1'b1);
      step(add_i(3, 0, 0), 1'b1, 1'b0, 1'b1);
      check("x0_lu_stall", 32'(stall), 0);
      idle(3);

      // 20 freeze cycles saturate the 4-bit counter; reset mid-freeze
      step(lw_i(7, 1), 1'b1, 1'b0, 1'b1);
      step(32'h0, 1'b0, 1'b0, 1'b1);
      repeat (20) step(32'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("sat_freeze", 32'(freeze), 1);
      check("sat_cnt16", 32'(cnt), 25);
      check("sat_cnt4", 32'(cnt4), 15);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rfz_freeze", 32'(freeze), 0);
      check("rfz_stall", 32'(stall), 0);
      check("rfz_flush", 32'(flush), 0);
      check("rfz_xv", 32'(xv), 0);
      check("rfz_mv", 32'(mv), 0);
      check("rfz_wv", 32'(wv), 0);
      check("rfz_cnt", 32'(cnt), 0);
      check("rfz_cnt4", 32'(cnt4), 0);
      check("rfz_fwd1", 32'(fwd1), 32'(FWD_NONE));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall-cycle counter.
REQ-002 Ports: clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_n_i  input  1  synchronous, active-low reset, sampled on rising clk_i.
REQ-004 d_inst_i  input  32  instruction in decode stage.
REQ-005 d_valid_i  input  1  d_inst_i holds a real instruction.
REQ-006 x_branch_taken_i  input  1  branch/jump in X resolved taken this cycle.
REQ-007 m_mem_ready_i  input  1  data memory has completed the M-stage access.
REQ-008 stall_d_o  output  1  hold PC and D register this cycle.
REQ-009 bubble_x_o  output  1  load a NOP into X next edge.
REQ-010 flush_o  output  1  squash D-stage instruction; the fetch unit redirects PC.
REQ-011 freeze_o  output  1  hold every pipeline register (F, D, X, M, W).
REQ-012 fwd1_sel_o, fwd2_sel_o  output  fwd_sel_t (2)  operand source for the X-stage rs1/rs2.
REQ-013 x_valid_o, m_valid_o, w_valid_o  output  1  stage holds a valid instruction.
REQ-014 stall_cycles_o  output  CNT_W  saturating count of stall_d_o or freeze_o cycles.

Function
REQ-015 The unit keeps shadow X/M/W registers: valid, opcode[6:0], rd[4:0], rs1[4:0], rs2[4:0].
REQ-016 Register usage: rd written by RTYPE, ITYPE_ALU, LOAD, JAL; rs1 read by RTYPE, ITYPE_ALU, LOAD, STORE, BRANCH; rs2 read by RTYPE, STORE, BRANCH; other opcodes use none.
REQ-017 rd==0 is never a write target: no forwarding and no hazard against x0.
REQ-018 Priority, highest first: freeze, flush, load-use stall, normal advance.
REQ-019 freeze_o = M valid AND M opcode in {LOAD, STORE} AND m_mem_ready_i==0, combinational; while frozen all shadow registers hold and stall_d_o, bubble_x_o, flush_o are 0.
REQ-020 flush_o = x_branch_taken_i AND X valid AND NOT freeze_o; next edge X.valid becomes 0 (the D instruction is discarded); load-use stall is suppressed that cycle.
REQ-021 Load-use: X valid, X opcode LOAD, X rd!=0, D valid, and D reads a register equal to X rd -> stall_d_o=1 and bubble_x_o=1 for exactly one cycle (the hazard clears once the load reaches M).
REQ-022 Normal advance: X<=D-decoded (valid=d_valid_i), M<=X, W<=M; with bubble, X.valid<=0 while M and W still advance.
REQ-023 fwd1_sel_o: FWD_M if M valid, M writes rd, M rd!=0, M rd==X rs1; else FWD_W under the same test on W; else FWD_NONE. M wins when both match; fwd2_sel_o is the same against rs2.
REQ-024 Forward selects are FWD_NONE whenever X is not valid or X does not read that source.
REQ-025 Forward from M is never produced for an M-stage LOAD (prevented by REQ-021); if it would occur, FWD_NONE is output.
REQ-026 stall_cycles_o increments by 1 on each cycle with stall_d_o|freeze_o and holds at all-ones (no wrap).

Reset
REQ-027 While rst_n_i==0 at a rising edge: all shadow valids=0, opcode/rd/rs=0, stall_cycles_o=0.
REQ-028 After reset, every output is 0 and the forward selects are FWD_NONE until a valid instruction enters X.
REQ-029 Reset asserted mid-freeze or mid-stall discards the pending operation; no stall or freeze carries past reset.

Structure
REQ-030 fwd_sel_t {FWD_NONE=0, FWD_M=1, FWD_W=2} is in proc_pkg; the LOAD, STORE, BRANCH and JAL opcode macros go in proc_define.sv beside RTYPE/ITYPE_ALU.
REQ-031 One combinational sub-module, inst_reg_use: input opcode; outputs uses_rs1, uses_rs2, writes_rd. It is instantiated for D and shared by the hazard and forwarding logic.

Verification
REQ-032 add x5,x1,x2 then add x6,x5,x3 back-to-back -> cycle the second is in X: fwd1_sel_o=FWD_M, no stall.
REQ-033 lw x7,0(x1) then add x8,x7,x7 -> stall_d_o=bubble_x_o=1 for exactly 1 cycle; next cycle fwd1_sel_o=fwd2_sel_o=FWD_W; stall_cycles_o=1.
REQ-034 lw in M with m_mem_ready_i low for 3 cycles -> freeze_o=1 for 3 cycles, shadow state unchanged, stall_cycles_o+=3; releases on the ready cycle.
REQ-035 x_branch_taken_i=1 while D holds a load-use dependent of X -> flush_o=1, stall_d_o=0, next x_valid_o=0.
REQ-036 add x0,x1,x2 then add x3,x0,x0 -> fwd selects FWD_NONE, no stall; with CNT_W=4, 20 stall cycles leave stall_cycles_o=15.
REQ-037 Reset pulsed during freeze -> next cycle all outputs 0, x/m/w_valid_o=0.
